// File: rtl/cust_instr_responder.sv
// Custom-0 offload responder: queues accepted instructions and executes them in order.
// Single-cycle ALU ops and CLZ finish in one cycle; MUL uses a 32-step shift-add unit.
module cust_instr_responder #(
  parameter logic [6:0]  OPCODE = 7'b0001011,
  parameter int unsigned QDEPTH = 2
) (
  input  logic        UserCLK,
  input  logic        RESETn,
  input  logic        ISSUE_VALID,
  input  logic [31:0] ISSUE_INSTR,
  input  logic [31:0] ISSUE_OPA,
  input  logic [31:0] ISSUE_OPB,
  input  logic [3:0]  ISSUE_ID,
  output logic        ISSUE_READY,
  output logic        ISSUE_ACCEPT,
  output logic        RESULT_VALID,
  output logic [3:0]  RESULT_ID,
  output logic [4:0]  RESULT_RD,
  output logic [31:0] RESULT
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(QDEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(QDEPTH - 1);

  localparam logic [2:0] F3Add = 3'b000;
  localparam logic [2:0] F3Sub = 3'b001;
  localparam logic [2:0] F3Xor = 3'b010;
  localparam logic [2:0] F3And = 3'b011;
  localparam logic [2:0] F3Or  = 3'b100;
  localparam logic [2:0] F3Mul = 3'b101;
  localparam logic [2:0] F3Clz = 3'b110;
  localparam logic [2:0] F3Bad = 3'b111;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] opa;
    logic [31:0] opb;
  } entry_t;

  typedef enum logic {StIdle, StMul} state_t;

  // Bits above funct3 carry no meaning for this block.
  logic unused_instr;
  assign unused_instr = ^ISSUE_INSTR[31:15];

  // Issue side
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;
  entry_t          queue_q [QDEPTH];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;

  // Execute side
  state_t      state_q;
  logic [4:0]  mul_cnt_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] mul_acc_q;
  logic [3:0]  mul_id_q;
  logic [4:0]  mul_rd_q;
  logic [31:0] mul_acc_step;
  logic [31:0] alu_res;
  logic [5:0]  clz_cnt;

  assign ISSUE_ACCEPT = (ISSUE_INSTR[6:0] == OPCODE) && (ISSUE_INSTR[14:12] != F3Bad);
  // Readiness comes from the registered count only, so a full queue stays closed even
  // in a cycle where the head is being popped.
  assign ISSUE_READY  = (count_q != CntFull);
  assign push         = ISSUE_VALID && ISSUE_READY && ISSUE_ACCEPT;
  assign pop          = (state_q == StIdle) && (count_q != '0);

  assign push_entry = '{
    id:     ISSUE_ID,
    rd:     ISSUE_INSTR[11:7],
    funct3: ISSUE_INSTR[14:12],
    opa:    ISSUE_OPA,
    opb:    ISSUE_OPB
  };

  assign head = queue_q[rptr_q];

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        queue_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        queue_q[wptr_q] <= push_entry;
        wptr_q          <= (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    clz_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (head.opa[i]) begin
        clz_cnt = 6'(31 - i);
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (head.funct3)
      F3Add:   alu_res = head.opa + head.opb;
      F3Sub:   alu_res = head.opa - head.opb;
      F3Xor:   alu_res = head.opa ^ head.opb;
      F3And:   alu_res = head.opa & head.opb;
      F3Or:    alu_res = head.opa | head.opb;
      F3Clz:   alu_res = {26'd0, clz_cnt};
      default: alu_res = '0;
    endcase
  end

  // Multiplicand shifts left, multiplier shifts right; one partial product per cycle.
  assign mul_acc_step = mul_acc_q + (mul_b_q[0] ? mul_a_q : 32'd0);

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= StIdle;
      mul_cnt_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_acc_q    <= '0;
      mul_id_q     <= '0;
      mul_rd_q     <= '0;
      RESULT_VALID <= 1'b0;
      RESULT_ID    <= '0;
      RESULT_RD    <= '0;
      RESULT       <= '0;
    end else begin
      RESULT_VALID <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            if (head.funct3 == F3Mul) begin
              mul_a_q   <= head.opa;
              mul_b_q   <= head.opb;
              mul_acc_q <= '0;
              mul_cnt_q <= '0;
              mul_id_q  <= head.id;
              mul_rd_q  <= head.rd;
              state_q   <= StMul;
            end else begin
              RESULT_VALID <= 1'b1;
              RESULT_ID    <= head.id;
              RESULT_RD    <= head.rd;
              RESULT       <= alu_res;
            end
          end
        end
        StMul: begin
          mul_acc_q <= mul_acc_step;
          mul_a_q   <= {mul_a_q[30:0], 1'b0};
          mul_b_q   <= {1'b0, mul_b_q[31:1]};
          mul_cnt_q <= mul_cnt_q + 1'b1;
          if (mul_cnt_q == 5'd31) begin
            RESULT_VALID <= 1'b1;
            RESULT_ID    <= mul_id_q;
            RESULT_RD    <= mul_rd_q;
            RESULT       <= mul_acc_step;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cust_instr_responder.sv
// Directed bench for cust_instr_responder with a cycle-tagged result scoreboard.
module tb_cust_instr_responder;

  localparam logic [6:0] OpCust = 7'b0001011;
  localparam logic [6:0] OpReg  = 7'b0110011;

  logic        UserCLK;
  logic        RESETn;
  logic        ISSUE_VALID;
  logic [31:0] ISSUE_INSTR;
  logic [31:0] ISSUE_OPA;
  logic [31:0] ISSUE_OPB;
  logic [3:0]  ISSUE_ID;
  logic        ISSUE_READY;
  logic        ISSUE_ACCEPT;
  logic        RESULT_VALID;
  logic [3:0]  RESULT_ID;
  logic [4:0]  RESULT_RD;
  logic [31:0] RESULT;

  cust_instr_responder #(
    .OPCODE(OpCust),
    .QDEPTH(2)
  ) dut (
    .UserCLK     (UserCLK),
    .RESETn      (RESETn),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_INSTR (ISSUE_INSTR),
    .ISSUE_OPA   (ISSUE_OPA),
    .ISSUE_OPB   (ISSUE_OPB),
    .ISSUE_ID    (ISSUE_ID),
    .ISSUE_READY (ISSUE_READY),
    .ISSUE_ACCEPT(ISSUE_ACCEPT),
    .RESULT_VALID(RESULT_VALID),
    .RESULT_ID   (RESULT_ID),
    .RESULT_RD   (RESULT_RD),
    .RESULT      (RESULT)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int n;
    case (f3)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a ^ b;
      3'b011: return a & b;
      3'b100: return a | b;
      3'b101: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      3'b110: begin
        n = 0;
        while (n < 32 && a[31 - n] == 1'b0) n++;
        return 32'(n);
      end
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock and compare any result strobe against the scoreboard head.
  task automatic step();
    exp_t e;
    @(posedge UserCLK);
    #1;
    cyc++;
    if (RESULT_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {32'd0, RESULT}, 64'hDEAD_0000_0000_0000);
      end else begin
        e = sb.pop_front();
        check("result", {32'd0, RESULT}, {32'd0, e.res});
        check("result_id", {60'd0, RESULT_ID}, {60'd0, e.id});
        check("result_rd", {59'd0, RESULT_RD}, {59'd0, e.rd});
        check("result_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive one request for a cycle; lat is the expected strobe cycle relative to this one.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] id,
                       input int lat);
    logic acc_exp;
    exp_t e;
    ISSUE_VALID = 1'b1;
    ISSUE_INSTR = {17'd0, f3, rd, op};
    ISSUE_OPA   = a;
    ISSUE_OPB   = b;
    ISSUE_ID    = id;
    #1;
    acc_exp = (op == OpCust) && (f3 != 3'b111);
    check("issue_accept", {63'd0, ISSUE_ACCEPT}, {63'd0, acc_exp});
    check("issue_ready", {63'd0, ISSUE_READY}, 64'd1);
    if (acc_exp) begin
      e.id  = id;
      e.rd  = rd;
      e.res = model(f3, a, b);
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    step();
    ISSUE_VALID = 1'b0;
  endtask

  int t0;

  initial begin
    RESETn      = 1'b0;
    ISSUE_VALID = 1'b0;
    ISSUE_INSTR = '0;
    ISSUE_OPA   = '0;
    ISSUE_OPB   = '0;
    ISSUE_ID    = '0;
    idle(3);
    check("reset_valid", {63'd0, RESULT_VALID}, 64'd0);
    check("reset_result", {32'd0, RESULT}, 64'd0);
    check("reset_id_rd", {55'd0, RESULT_ID, RESULT_RD}, 64'd0);
    check("reset_ready", {63'd0, ISSUE_READY}, 64'd1);
    RESETn = 1'b1;
    idle(2);

    // ADD with wraparound, then SUB/XOR/AND/OR back to back, plus rd=0.
    issue(OpCust, 3'b000, 5'd5, 32'hFFFF_FFFF, 32'd2, 4'd3, 2);
    idle(4);
    issue(OpCust, 3'b001, 5'd1, 32'd5, 32'd7, 4'd1, 2);
    issue(OpCust, 3'b010, 5'd2, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 4'd2, 2);
    issue(OpCust, 3'b011, 5'd3, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 4'd4, 2);
    issue(OpCust, 3'b100, 5'd4, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 4'd5, 2);
    issue(OpCust, 3'b000, 5'd0, 32'h1234_5678, 32'h1111_1111, 4'd6, 2);
    idle(4);

    // Rejected requests must never produce a strobe.
    issue(OpReg, 3'b000, 5'd9, 32'd1, 32'd1, 4'd8, 0);
    idle(20);
    issue(OpCust, 3'b111, 5'd9, 32'd1, 32'd1, 4'd9, 0);
    idle(40);

    // MUL latency and result hold afterwards.
    issue(OpCust, 3'b101, 5'd10, 32'h0001_0001, 32'h0001_0001, 4'd7, 34);
    idle(40);
    check("result_hold", {32'd0, RESULT}, 64'h0002_0001);
    check("valid_low_idle", {63'd0, RESULT_VALID}, 64'd0);

    // Back-pressure: MUL then two ADDs fill the queue until the MUL drains.
    t0 = cyc;
    issue(OpCust, 3'b101, 5'd11, 32'hDEAD_BEEF, 32'h1234_5679, 4'd10, 34);
    issue(OpCust, 3'b000, 5'd12, 32'd100, 32'd23, 4'd11, 34);
    issue(OpCust, 3'b000, 5'd13, 32'd200, 32'd45, 4'd12, 34);
    check("full_ready_t3", {63'd0, ISSUE_READY}, 64'd0);
    idle(20);
    check("full_ready_t23", {63'd0, ISSUE_READY}, 64'd0);
    while (cyc < t0 + 35) step();
    check("drain_ready", {63'd0, ISSUE_READY}, 64'd1);
    idle(6);

    // CLZ edge values back to back.
    issue(OpCust, 3'b110, 5'd14, 32'h0000_0000, 32'd0, 4'd13, 2);
    issue(OpCust, 3'b110, 5'd15, 32'h0000_8000, 32'd0, 4'd14, 2);
    issue(OpCust, 3'b110, 5'd16, 32'h8000_0000, 32'd0, 4'd15, 2);
    idle(4);

    // Reset in the middle of a MUL discards it.
    issue(OpCust, 3'b101, 5'd17, 32'd3, 32'd5, 4'd2, 34);
    idle(11);
    RESETn = 1'b0;
    #1;
    sb.delete();
    check("mid_reset_valid", {63'd0, RESULT_VALID}, 64'd0);
    check("mid_reset_ready", {63'd0, ISSUE_READY}, 64'd1);
    idle(2);
    RESETn = 1'b1;
    step();
    check("post_reset_ready", {63'd0, ISSUE_READY}, 64'd1);
    idle(40);

    // Queue still usable after reset.
    issue(OpCust, 3'b000, 5'd18, 32'd40, 32'd2, 4'd5, 2);
    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cust_instr_responder.md
CUST_INSTR_RESPONDER -- requirements
Module: cust_instr_responder

Interface
REQ-001 SHALL have parameter OPCODE, default 7'b0001011, the only major opcode the block accepts (custom-0).
REQ-002 SHALL have parameter QDEPTH, default 2, the accepted-instruction queue depth (power of two, >=2).
REQ-003 SHALL have one clock, UserCLK; reset is asynchronous and active-low, named RESETn.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- UserCLK  in  1  clock
- RESETn  in  1  async active-low reset
- ISSUE_VALID  in  1  offload request valid
- ISSUE_INSTR  in  32  instruction word
- ISSUE_OPA  in  32  rs1 value
- ISSUE_OPB  in  32  rs2 value
- ISSUE_ID  in  4  transaction tag
- ISSUE_READY  out  1  block can take a request this cycle
- ISSUE_ACCEPT  out  1  request is ours; qualified by ISSUE_VALID&&ISSUE_READY
- RESULT_VALID  out  1  one-cycle result strobe, no back-pressure
- RESULT_ID  out  4  tag of the returned transaction
- RESULT_RD  out  5  destination register, INSTR[11:7]
- RESULT  out  32  result data

Function
REQ-005 SHALL complete a handshake only in a cycle where ISSUE_VALID and ISSUE_READY are both 1.
REQ-006 SHALL drive ISSUE_READY = 1 iff the queue is not full; ISSUE_READY SHALL NOT depend on ISSUE_VALID.
REQ-007 SHALL drive ISSUE_ACCEPT combinationally = (INSTR[6:0]==OPCODE) && (INSTR[14:12]!=3'b111).
REQ-008 SHALL push {ID, rd, funct3, OPA, OPB} into the FIFO queue on a handshake with ISSUE_ACCEPT=1; a rejected handshake SHALL leave all state unchanged.
REQ-009 SHALL decode funct3: 000 ADD, 001 SUB (A-B), 010 XOR, 011 AND, 100 OR, 101 MUL (low 32 bits of A*B), 110 CLZ(A) (CLZ(0)=32); 32-bit arithmetic, wraparound, no flags.
REQ-010 SHALL implement an execute FSM with states IDLE and MUL.
REQ-011 IDLE with queue non-empty: pop head; single-cycle op -> register result and stay IDLE; MUL -> load operands, clear 5-bit counter, go to MUL.
REQ-012 MUL: one shift-add step per cycle for 32 cycles; at count 31 register result, return to IDLE; no pop while in MUL.
REQ-013 Latency from handshake cycle T: single-cycle op RESULT_VALID in T+2; MUL in T+34, when the queue and FSM are idle at T.
REQ-014 Back-to-back single-cycle ops SHALL sustain one result per cycle; results SHALL return in issue order.
REQ-015 RESULT_VALID SHALL be high for exactly one cycle per accepted instruction; RESULT_ID/RD/RESULT SHALL be valid only while RESULT_VALID=1 and hold their value otherwise.
REQ-016 rd=0 instructions SHALL still produce a result strobe.
REQ-017 Full queue with simultaneous pop: ISSUE_READY stays 0 that cycle (computed from registered count); no push/pop collision on the same entry.
REQ-018 Pointers SHALL wrap modulo QDEPTH; the count SHALL never exceed QDEPTH or go below 0.

Reset
REQ-019 RESETn low SHALL immediately clear the queue, the FSM (IDLE), the counter, RESULT_VALID=0, RESULT_ID=0, RESULT_RD=0, RESULT=0; ISSUE_READY=1 after reset.
REQ-020 Reset during MUL or with a non-empty queue SHALL discard all in-flight work and produce no result strobe.

Verification
REQ-021 ADD: INSTR funct3=000 rd=5 opcode=0001011, OPA=0xFFFFFFFF, OPB=2, ID=3 -> ISSUE_ACCEPT=1; T+2: RESULT_VALID=1, RESULT=0x00000001, RD=5, ID=3.
REQ-022 Reject: opcode 0110011, or funct3=111 -> ISSUE_ACCEPT=0, no RESULT_VALID within 40 cycles.
REQ-023 MUL: OPA=0x00010001, OPB=0x00010001, ID=7 -> RESULT=0x00020001 at T+34, one-cycle strobe.
REQ-024 Back-pressure: issue MUL then 2 ADDs -> ISSUE_READY=0 while the queue holds 2; results in order MUL, ADD, ADD.
REQ-025 CLZ: OPA=0 -> 32; OPA=0x00008000 -> 16; back-to-back issue -> results in consecutive cycles.
REQ-026 Reset at MUL cycle 10 -> RESULT_VALID never asserts, ISSUE_READY=1 on the first cycle after release.
